// File: rtl/vga_pkg.sv
// Shared raster constants, colour palette, pattern modes and FSM state encoding
// for the VGA pixel source path.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam logic [23:0] COLOUR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COLOUR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COLOUR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COLOUR_GREEN   = 24'h00FF00;
    localparam logic [23:0] COLOUR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COLOUR_RED     = 24'hFF0000;
    localparam logic [23:0] COLOUR_BLUE    = 24'h0000FF;
    localparam logic [23:0] COLOUR_BLACK   = 24'h000000;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_FRAME    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = COLOUR_WHITE;
            3'd1:    c = COLOUR_YELLOW;
            3'd2:    c = COLOUR_CYAN;
            3'd3:    c = COLOUR_GREEN;
            3'd4:    c = COLOUR_MAGENTA;
            3'd5:    c = COLOUR_RED;
            3'd6:    c = COLOUR_BLUE;
            default: c = COLOUR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pattern_lut.sv
// Combinational test-pattern generator: maps raster position, pattern mode and
// frame index to a 24-bit RGB pixel.
module pattern_lut
    import vga_pkg::*;
(
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  mode_t       mode,
    input  logic [1:0]  frame_cnt,
    output logic [23:0] pix
);

    logic [2:0] bar_idx;
    logic       unused_y;

    // Bars are 80 pixels wide; positions beyond the last bar never occur in a 640-wide raster.
    assign bar_idx  = 3'(x / 10'd80);
    assign unused_y = ^{y[9], y[0]};

    always_comb begin
        pix = COLOUR_BLACK;
        case (mode)
            MODE_BARS:     pix = bar_colour(bar_idx);
            MODE_CHECKER:  pix = (x[5] ^ y[5]) ? COLOUR_BLACK : COLOUR_WHITE;
            MODE_GRADIENT: pix = {x[9:2], y[8:1], 8'h80};
            MODE_FRAME: begin
                case (frame_cnt)
                    2'd0: pix = COLOUR_RED;
                    2'd1: pix = COLOUR_GREEN;
                    2'd2: pix = COLOUR_BLUE;
                    2'd3: pix = COLOUR_WHITE;
                endcase
            end
            default:       pix = COLOUR_BLACK;
        endcase
    end

endmodule

// File: rtl/pattern_source.sv
// Raster test-pattern source feeding the display FIFO; a one-entry output
// register absorbs FIFO back-pressure so every pixel is written exactly once.
module pattern_source
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic        full,
    output logic        wr_en,
    output logic [23:0] pixelData,
    output logic        sof,
    output logic        busy
);

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    state_t      state_q, state_d;
    logic [9:0]  x_q, y_q;
    logic [1:0]  frame_cnt_q;
    mode_t       mode_q;
    logic        out_valid_q;
    logic [23:0] out_pix_q;
    logic        out_sof_q;

    logic        load;
    logic        last_px;
    logic        latch_mode;
    logic        frame_adv;
    logic [23:0] lut_pix;

    pattern_lut u_lut (
        .x         (x_q),
        .y         (y_q),
        .mode      (mode_q),
        .frame_cnt (frame_cnt_q),
        .pix       (lut_pix)
    );

    assign wr_en     = out_valid_q & ~full;
    assign pixelData = out_pix_q;
    assign sof       = out_sof_q;
    assign busy      = (state_q != ST_IDLE);
    assign last_px   = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        latch_mode = 1'b0;
        frame_adv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_RUN;
                    latch_mode = 1'b1;
                end
            end
            ST_RUN: begin
                load = ~out_valid_q | wr_en;
                // Enable is only consulted when the final pixel is loaded, so frames are never cut short.
                if (load && last_px) begin
                    if (enable) begin
                        latch_mode = 1'b1;
                        frame_adv  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (wr_en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            x_q         <= 10'd0;
            y_q         <= 10'd0;
            frame_cnt_q <= 2'd0;
            mode_q      <= MODE_BARS;
            out_valid_q <= 1'b0;
            out_pix_q   <= 24'd0;
            out_sof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_mode) mode_q <= mode_t'(mode);
            if (frame_adv) frame_cnt_q <= frame_cnt_q + 2'd1;

            if (state_q == ST_IDLE) begin
                x_q <= 10'd0;
                y_q <= 10'd0;
            end else if (load) begin
                if (x_q == X_LAST) begin
                    x_q <= 10'd0;
                    y_q <= (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
                end else begin
                    x_q <= x_q + 10'd1;
                end
            end

            if (load) begin
                out_valid_q <= 1'b1;
                out_pix_q   <= lut_pix;
                out_sof_q   <= (x_q == 10'd0) && (y_q == 10'd0);
            end else if (wr_en) begin
                out_valid_q <= 1'b0;
                out_sof_q   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pattern_source.md
# pattern_source

Single-clock raster pixel source that fills the display FIFO feeding the VGA timing stage. It generates 640x480 frames of 24-bit RGB test patterns in raster order (left to right, top to bottom) and pushes one pixel per accepted write, throttled by the FIFO `full` flag. A one-entry output register decouples pattern generation from FIFO back-pressure, so no pixel is ever dropped or duplicated.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `V_ACTIVE`, 480, active lines per frame
- `clk`  in  1  pixel-source clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset (asserted when 0)
- `enable`  in  1  level; 1 = produce frames, 0 = stop at next frame boundary
- `mode`  in  2  pattern select; sampled only at frame start
- `full`  in  1  FIFO full flag; a write is accepted only when `full`=0
- `wr_en`  out  1  FIFO write strobe; equals `out_valid & ~full`
- `pixelData`  out  24  {R[23:16], G[15:8], B[7:0]} for the current write
- `sof`  out  1  high with `wr_en` for pixel (0,0) of each frame
- `busy`  out  1  high in any state other than IDLE

## Operation
- Counters: `x` 0..H_ACTIVE-1, `y` 0..V_ACTIVE-1 (10 bits each); `x` wraps to 0 and `y` increments at `x`=H_ACTIVE-1; `y` wraps to 0 at the last pixel. `frame_cnt` is 2 bits and wraps 3→0.
- Output register {`out_valid`, `out_pix`, `out_sof`} loads the pattern for (`x`,`y`) when it is empty or being written this cycle (`wr_en`=1); the counters advance on every load.
- Patterns (`mode_q`, latched from `mode`):
  - 0 colour bars: bar = x/80, order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - 1 checkerboard: x[5]^y[5] = 0 → FFFFFF, else 000000.
  - 2 gradient: R = x[9:2], G = y[8:1], B = 8'h80.
  - 3 frame cycle: solid colour by `frame_cnt`: 0 red, 1 green, 2 blue, 3 white.
- FSM states:
  - IDLE: `out_valid`=0, counters held at 0. `enable`=1 → latch `mode_q`, go to RUN.
  - RUN: load pixels as above. When the load of (H_ACTIVE-1, V_ACTIVE-1) occurs: if `enable`=1, re-latch `mode_q`, increment `frame_cnt`, stay in RUN; else go to DRAIN.
  - DRAIN: no loads; when `wr_en`=1 (final pixel written) → IDLE.
- `enable` deasserted mid-frame does not truncate the frame; it is checked only at the last-pixel load.
- `mode` changes mid-frame have no effect until the next frame start.

## Timing
- Reset (`rst`=0 at a clock edge): state IDLE, `x`=`y`=0, `frame_cnt`=0, `mode_q`=0, `out_valid`=0, `out_pix`=0. Outputs: `wr_en`=0, `pixelData`=0, `sof`=0, `busy`=0. A reset mid-frame discards the frame; the next frame starts at (0,0).
- Latency: `enable` sampled 1 in IDLE at edge N → RUN at N; first load at N+1; `wr_en`=1 and `sof`=1 during cycle N+1..N+2 if `full`=0.
- Throughput: one pixel per clock while `full`=0; back-to-back frames with no gap cycle.
- `full`=1: `wr_en`=0 that cycle; `pixelData`/`sof` are held stable; counters do not advance.
- `full` toggling every cycle: each pixel is written exactly once, in order.
- `wr_en` and `pixelData` are combinational only from `out_valid`, `out_pix`, and `full`; no other input path reaches them.

## Structure
- Shared package `vga_pkg`: H_ACTIVE/V_ACTIVE defaults, the 8 colour-bar constants, the mode encodings, and the FSM state typedef (IDLE, RUN, DRAIN).
- One sub-module: `pattern_lut`, purely combinational (`x`, `y`, `mode_q`, `frame_cnt`) → 24-bit pixel. The FSM, counters, and output register live in `pattern_source`.

## Test plan
- Reset then `enable`=1, `mode`=0, `full`=0 → 307200 writes; pixel (0,0)=FFFFFF with `sof`=1; (80,0)=FFFF00; (639,479)=000000; next write is (0,0) with `sof`=1.
- `mode`=1, random `full` at 50% → write count per frame is exactly 307200; (32,0)=000000; (32,32)=FFFFFF; no gaps or repeats in scoreboard order.
- `mode`=3 over 5 frames → solid colours FF0000, 00FF00, 0000FF, FFFFFF, then FF0000 again.
- `mode` switched 0→2 at pixel 1000 → rest of frame stays bars; next frame (100,10) = {8'd25, 8'd5, 8'h80}.
- `enable` dropped at pixel 5000 → frame completes; after the last write `busy`=0 the next cycle; no further `wr_en`.
- `rst`=0 mid-frame with `full`=1 → next cycle all outputs 0, state IDLE; after release the first write is (0,0) with `sof`=1.
